// File: rtl/pipeline_interlock_ctrl_pkg.sv
// Shared ISA definitions for the pipeline interlock controller: instruction
// field positions, opcodes that matter to hazard detection, and FSM states.
package proc_isa_pkg;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int IMM_BIT = 26;
   localparam int RD_MSB  = 25;
   localparam int RD_LSB  = 22;
   localparam int RS1_MSB = 21;
   localparam int RS1_LSB = 18;
   localparam int RS2_MSB = 17;
   localparam int RS2_LSB = 14;

   typedef logic [4:0] opcode_t;
   typedef logic [3:0] reg_t;

   localparam opcode_t OP_ALU_LAST  = 5'b00111;
   localparam opcode_t OP_DIV       = 5'b00011;
   localparam opcode_t OP_MOD       = 5'b00100;
   localparam opcode_t OP_CMP_FIRST = 5'b01010;
   localparam opcode_t OP_CMP_LAST  = 5'b01100;
   localparam opcode_t OP_NOP       = 5'b01101;
   localparam opcode_t OP_LD        = 5'b01110;
   localparam opcode_t OP_ST        = 5'b01111;
   localparam opcode_t OP_RET       = 5'b10100;

   // ret implicitly reads the return-address register
   localparam reg_t RA_REG = 4'hF;

   typedef enum logic {
      RUN,
      DIV_BUSY
   } state_t;

endpackage

// File: rtl/pipeline_interlock_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and the interlock
// controller (slave).
interface pipeline_interlock_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [31:0]      input_OF_IR;
   logic [31:0]      input_EX_IR;
   logic             OF_valid;
   logic             EX_valid;
   logic             is_branch_taken;
   logic             pc_stall;
   logic             if_of_stall;
   logic             if_of_flush;
   logic             of_ex_bubble;
   logic             ex_hold;
   logic             ma_bubble;
   logic             div_start;
   logic             div_done;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output input_OF_IR, input_EX_IR, OF_valid, EX_valid, is_branch_taken,
      input  pc_stall, if_of_stall, if_of_flush, of_ex_bubble, ex_hold,
             ma_bubble, div_start, div_done, stall_cycles
   );

   modport slave (
      input  input_OF_IR, input_EX_IR, OF_valid, EX_valid, is_branch_taken,
      output pc_stall, if_of_stall, if_of_flush, of_ex_bubble, ex_hold,
             ma_bubble, div_start, div_done, stall_cycles
   );
endinterface

// File: rtl/pipeline_interlock_ctrl_of_src_decode.sv
// Decodes which source registers the instruction in OF reads, for load-use
// hazard detection.
module of_src_decode
   import proc_isa_pkg::*;
(
   input  opcode_t opcode,
   input  logic    imm,
   output logic    reads_rs1,
   output logic    reads_rs2,
   output logic    reads_rd,
   output logic    reads_ra
);

   always_comb begin
      reads_rs1 = (opcode <= OP_ALU_LAST)
               || (opcode >= OP_CMP_FIRST && opcode <= OP_CMP_LAST)
               || (opcode == OP_LD)
               || (opcode == OP_ST);
      reads_rs2 = (opcode <= OP_CMP_LAST) && !imm;
      // a store's rd field names the data register being written to memory
      reads_rd  = (opcode == OP_ST);
      reads_ra  = (opcode == OP_RET);
   end

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Pipeline interlock: multi-cycle div/mod hold, taken-branch flush and
// load-use stall, with a saturating count of PC-stall cycles.
module pipeline_interlock_ctrl
   import proc_isa_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 8,
   parameter int unsigned CNT_W      = 16
) (
   input logic                      clk,
   input logic                      reset,
   pipeline_interlock_ctrl_if.slave bus
);

   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

   state_t           state;
   logic [7:0]       div_cnt;
   logic [CNT_W-1:0] stall_cnt;

   opcode_t of_op, ex_op;
   reg_t    of_rd, of_rs1, of_rs2, ex_rd;
   logic    of_imm;
   logic    reads_rs1, reads_rs2, reads_rd, reads_ra;
   logic    in_run, ex_is_div, start, busy_stall, done, div_hold;
   logic    flush, hazard, load_use, stall;
   logic    unused_ir_bits;

   assign of_op  = bus.input_OF_IR[OPC_MSB:OPC_LSB];
   assign of_imm = bus.input_OF_IR[IMM_BIT];
   assign of_rd  = bus.input_OF_IR[RD_MSB:RD_LSB];
   assign of_rs1 = bus.input_OF_IR[RS1_MSB:RS1_LSB];
   assign of_rs2 = bus.input_OF_IR[RS2_MSB:RS2_LSB];
   assign ex_op  = bus.input_EX_IR[OPC_MSB:OPC_LSB];
   assign ex_rd  = bus.input_EX_IR[RD_MSB:RD_LSB];
   assign unused_ir_bits = ^{bus.input_OF_IR[13:0], bus.input_EX_IR[26], bus.input_EX_IR[21:0]};

   of_src_decode u_of_src_decode (
      .opcode    (of_op),
      .imm       (of_imm),
      .reads_rs1 (reads_rs1),
      .reads_rs2 (reads_rs2),
      .reads_rd  (reads_rd),
      .reads_ra  (reads_ra)
   );

   // Priority: reset > divide (start or busy) > taken branch > load-use.
   always_comb begin
      in_run     = (state == RUN);
      ex_is_div  = bus.EX_valid && (ex_op == OP_DIV || ex_op == OP_MOD);
      start      = !reset && in_run && ex_is_div;
      busy_stall = !reset && !in_run && (div_cnt > 8'd1);
      done       = !reset && !in_run && (div_cnt <= 8'd1);
      div_hold   = start || busy_stall;
      flush      = !reset && in_run && !ex_is_div && bus.is_branch_taken;
      hazard     = (reads_rs1 && of_rs1 == ex_rd) || (reads_rs2 && of_rs2 == ex_rd)
                || (reads_rd && of_rd == ex_rd) || (reads_ra && RA_REG == ex_rd);
      load_use   = !reset && in_run && !ex_is_div && !bus.is_branch_taken
                && bus.EX_valid && bus.OF_valid && (ex_op == OP_LD) && hazard;
      stall      = div_hold || load_use;

      bus.pc_stall     = stall;
      bus.if_of_stall  = stall && !flush;
      bus.if_of_flush  = flush;
      bus.of_ex_bubble = flush || load_use;
      bus.ex_hold      = div_hold;
      bus.ma_bubble    = div_hold;
      bus.div_start    = start;
      bus.div_done     = done;
      bus.stall_cycles = stall_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         div_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (ex_is_div) begin
                  state   <= DIV_BUSY;
                  div_cnt <= DIV_LOAD;
               end
            end
            DIV_BUSY: begin
               if (div_cnt > 8'd1) begin
                  div_cnt <= div_cnt - 8'd1;
               end else begin
                  state   <= RUN;
                  div_cnt <= '0;
               end
            end
            default: begin
               state   <= RUN;
               div_cnt <= '0;
            end
         endcase
         if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Directed and randomized checks of pipeline_interlock_ctrl against a
// cycle-level behavioural model of the interlock rules.
module tb_pipeline_interlock_ctrl;

   localparam int DIVC  = 8;
   localparam int CW    = 8;
   localparam int MAXSC = (1 << CW) - 1;

   // control vector bit order: pc_stall, if_of_stall, if_of_flush, of_ex_bubble,
   // ex_hold, ma_bubble, div_start, div_done
   localparam logic [7:0] C_IDLE  = 8'b0000_0000;
   localparam logic [7:0] C_LDU   = 8'b1101_0000;
   localparam logic [7:0] C_DIV0  = 8'b1100_1110;
   localparam logic [7:0] C_DIVB  = 8'b1100_1100;
   localparam logic [7:0] C_DONE  = 8'b0000_0001;
   localparam logic [7:0] C_FLUSH = 8'b0011_0000;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   age;      // -1: no divide in progress; else cycles since div_start
   int   exp_sc;
   int   cyc;
   logic [7:0] last_ctl;

   pipeline_interlock_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_interlock_ctrl #(
      .DIV_CYCLES (DIVC),
      .CNT_W      (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input int op, input int i, input int rd,
                                      input int rs1, input int rs2);
      return {5'(op), 1'(i), 4'(rd), 4'(rs1), 4'(rs2), 14'h0};
   endfunction

   // Set of registers an OF instruction reads, as a 16-bit membership mask.
   function automatic logic [15:0] read_set(input logic [31:0] ir);
      int op;
      logic [15:0] m;
      op = int'(ir[31:27]);
      m  = '0;
      if (op <= 7 || (op >= 10 && op <= 12) || op == 14 || op == 15) m[ir[21:18]] = 1'b1;
      if (op <= 12 && ir[26] == 1'b0) m[ir[17:14]] = 1'b1;
      if (op == 15) m[ir[25:22]] = 1'b1;
      if (op == 20) m[15] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic [31:0] oi, input logic [31:0] ei,
                        input logic ov, input logic ev, input logic br);
      logic [7:0]  e;
      logic [15:0] m;
      int          eop;
      @(negedge clk);
      reset               = r;
      bus.input_OF_IR     = oi;
      bus.input_EX_IR     = ei;
      bus.OF_valid        = ov;
      bus.EX_valid        = ev;
      bus.is_branch_taken = br;
      #2;
      eop = int'(ei[31:27]);
      m   = read_set(oi);
      e   = C_IDLE;
      if (r)                            e = C_IDLE;
      else if (age >= 1)                e = (age < DIVC - 1) ? C_DIVB : C_DONE;
      else if (ev && (eop == 3 || eop == 4)) e = C_DIV0;
      else if (br)                      e = C_FLUSH;
      else if (ev && ov && eop == 14 && m[ei[25:22]]) e = C_LDU;
      last_ctl = {bus.pc_stall, bus.if_of_stall, bus.if_of_flush, bus.of_ex_bubble,
                  bus.ex_hold, bus.ma_bubble, bus.div_start, bus.div_done};
      chk($sformatf("ctl@%0d", cyc), 32'(last_ctl), 32'(e));
      chk($sformatf("stall_cycles@%0d", cyc), 32'(bus.stall_cycles), 32'(exp_sc));
      @(posedge clk);
      if (r) begin
         age    = -1;
         exp_sc = 0;
      end else begin
         if (e[7] && exp_sc < MAXSC) exp_sc++;
         if (age >= 1)  age = (age == DIVC - 1) ? -1 : age + 1;
         else if (e[1]) age = 1;
      end
      cyc++;
      #1;
   endtask

   function automatic logic [31:0] rnd_ir();
      logic [4:0] ops [8];
      int r [3];
      ops = '{5'd0, 5'd3, 5'd4, 5'd14, 5'd15, 5'd20, 5'd13, 5'($urandom_range(0, 31))};
      for (int k = 0; k < 3; k++) begin
         r[k] = $urandom_range(0, 4);
         if (r[k] == 4) r[k] = 15;
      end
      return {ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 4'(r[0]), 4'(r[1]),
              4'(r[2]), 14'($urandom)};
   endfunction

   initial begin
      logic [31:0] ld3, add534, addi, addi_r3, st3, ld15, ret_i, divi, nop_i;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      age      = -1;
      exp_sc   = 0;
      ld3      = mk(14, 0, 3, 1, 0);
      add534   = mk(0, 0, 5, 3, 4);
      addi     = mk(0, 1, 5, 2, 0) | 32'd7;
      addi_r3  = mk(0, 1, 5, 2, 3);
      st3      = mk(15, 0, 3, 1, 0);
      ld15     = mk(14, 0, 15, 2, 0);
      ret_i    = mk(20, 0, 0, 0, 0);
      divi     = mk(3, 0, 2, 1, 1);
      nop_i    = mk(13, 0, 0, 0, 0);

      reset = 1'b1;
      bus.input_OF_IR = '0;
      bus.input_EX_IR = '0;
      bus.OF_valid = 1'b0;
      bus.EX_valid = 1'b0;
      bus.is_branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // reset held with a div and a branch presented: outputs stay quiet
      cycle(1, add534, divi, 1, 1, 1);
      chk("reset_ctl", 32'(last_ctl), 32'(C_IDLE));

      // load-use on rs1, then the bubble reaches EX
      cycle(0, add534, ld3, 1, 1, 0);
      chk("ldu_add", 32'(last_ctl), 32'(C_LDU));
      cycle(0, add534, nop_i, 1, 0, 0);
      chk("ldu_release", 32'(last_ctl), 32'(C_IDLE));
      chk("ldu_count", 32'(bus.stall_cycles), 32'd1);

      cycle(0, addi, ld3, 1, 1, 0);
      chk("ldu_imm_none", 32'(last_ctl), 32'(C_IDLE));
      cycle(0, addi_r3, ld3, 1, 1, 0);
      chk("ldu_imm_rs2field", 32'(last_ctl), 32'(C_IDLE));
      cycle(0, st3, ld3, 1, 1, 0);
      chk("ldu_store_rd", 32'(last_ctl), 32'(C_LDU));
      cycle(0, ret_i, ld15, 1, 1, 0);
      chk("ldu_ret_ra", 32'(last_ctl), 32'(C_LDU));
      cycle(0, add534, ld3, 0, 1, 0);
      chk("ldu_of_invalid", 32'(last_ctl), 32'(C_IDLE));

      // branch beats a pending load-use
      cycle(0, add534, ld3, 1, 1, 1);
      chk("branch_flush", 32'(last_ctl), 32'(C_FLUSH));

      // full divide: start, six busy stalls, release
      cycle(1, nop_i, nop_i, 0, 0, 0);
      for (int k = 0; k < DIVC; k++) begin
         cycle(0, add534, divi, 1, 1, 1);
         if (k == 0)             chk("div_start_c0", 32'(last_ctl), 32'(C_DIV0));
         else if (k < DIVC - 1)  chk("div_busy", 32'(last_ctl), 32'(C_DIVB));
         else                    chk("div_done_c7", 32'(last_ctl), 32'(C_DONE));
      end
      chk("div_count", 32'(bus.stall_cycles), 32'd7);
      cycle(0, nop_i, nop_i, 0, 0, 0);
      chk("div_after", 32'(last_ctl), 32'(C_IDLE));

      // reset while div_cnt == 4 abandons the divide
      for (int k = 0; k < 4; k++) cycle(0, nop_i, divi, 0, 1, 0);
      cycle(1, nop_i, divi, 0, 1, 0);
      chk("div_reset_ctl", 32'(last_ctl), 32'(C_IDLE));
      for (int k = 0; k < 5; k++) begin
         cycle(0, nop_i, nop_i, 0, 0, 0);
         chk("div_abandoned", 32'(last_ctl), 32'(C_IDLE));
      end
      cycle(0, nop_i, divi, 0, 1, 0);
      chk("div_restart_run", 32'(last_ctl), 32'(C_DIV0));
      for (int k = 1; k < DIVC; k++) cycle(0, nop_i, nop_i, 0, 0, 0);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 39) == 0), rnd_ir(), rnd_ir(),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 5) == 0));
      end

      // saturation: continuous load-use for 2^CW + 3 cycles
      cycle(1, nop_i, nop_i, 0, 0, 0);
      for (int k = 0; k < MAXSC + 4; k++) cycle(0, add534, ld3, 1, 1, 0);
      chk("sat_all_ones", 32'(bus.stall_cycles), 32'(MAXSC));
      cycle(0, add534, ld3, 1, 1, 0);
      chk("sat_hold", 32'(bus.stall_cycles), 32'(MAXSC));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
